// File: rtl/riscv_multiciclo_control.sv
// ---------------------------------------------------------------------------
// riscv_multiciclo_control
//   Control unit for a multicycle RV32I datapath that shares one memory for
//   instructions and data.  A Moore FSM sequences each instruction.  The ALU
//   decoder and the immediate-format decoder complete the unit.  The PC/IR
//   load in FETCH and the memory stalls in FETCH/MEMREAD/MEMWRITE are gated
//   by the memory ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   opcode       instr[6:0] from IR
//   funct3       instr[14:12]
//   funct7b5     instr[30]
//   zero         ALU zero flag
//   mem_ready    memory finished its access this cycle
//   pc_write     PC load enable
//   adr_src      memory address select (0 PC, 1 ALUOut)
//   mem_write    memory write enable
//   ir_write     IR/OldPC load enable
//   reg_write    register file write enable
//   alu_src_a    ALU A select (00 PC, 01 OldPC, 10 rs1, 11 zero)
//   alu_src_b    ALU B select (00 rs2, 01 ImmExt, 10 const 4)
//   result_src   result select (00 ALUOut, 01 Data, 10 ALU result)
//   alu_control  ALU operation, 3-bit code zero-extended to ALUCTRL_W
//   imm_src      immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   illegal      high while the FSM sits in TRAP
//   state_debug  current state encoding
// ---------------------------------------------------------------------------
module riscv_multiciclo_control #(
    parameter int ALUCTRL_W    = 3,
    parameter int IMMSRC_W     = 3,
    parameter int SUPPORT_JALR = 1,
    parameter int SUPPORT_BNE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [IMMSRC_W-1:0]  imm_src,
    output logic                 illegal,
    output logic [3:0]           state_debug
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operation from funct3.  funct7b5 selects SUB only for R-type
    // funct3 000, because in I-type it is part of the immediate.  SLTU
    // (011) has no ALU code and falls back to ADD.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_rtype);
        case (f3)
            3'b000:  alu_decode = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic       pc_write_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       adr_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] result_src_s;
    logic [2:0] alu_code_s;
    logic [2:0] imm_code_s;
    logic       bne_ok_s;
    logic       jalr_ok_s;

    assign bne_ok_s  = (SUPPORT_BNE != 0);
    assign jalr_ok_s = (SUPPORT_JALR != 0);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore control decode; the FETCH enables follow mem_ready.
    always_comb begin
        next_s       = state_r;
        pc_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        result_src_s = 2'b00;
        alu_code_s   = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                // PC+4 is computed and written back in the same cycle that
                // the instruction arrives.
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
                if (mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute OldPC+imm so BRANCH/JAL find their target in ALUOut.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: next_s = S_MEMADR;
                    OP_RTYPE:          next_s = S_EXECR;
                    OP_ITYPE:          next_s = S_EXECI;
                    OP_BRANCH:         next_s = S_BRANCH;
                    OP_JAL:            next_s = S_JAL;
                    OP_JALR:           next_s = jalr_ok_s ? S_JALR : S_TRAP;
                    OP_LUI:            next_s = S_LUI;
                    default:           next_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                // opcode[5] separates store (0100011) from load (0000011).
                if (opcode[5]) begin
                    next_s = S_MEMWRITE;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                next_s       = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write request is held until memory accepts it.
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b00;
                alu_code_s  = alu_decode(funct3, funct7b5, 1'b1);
                next_s      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_code_s  = alu_decode(funct3, funct7b5, 1'b0);
                next_s      = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = 2'b00;
                reg_write_s  = 1'b1;
                next_s       = S_FETCH;
            end
            S_BRANCH: begin
                // rs1-rs2 drives the zero flag; the target comes from ALUOut.
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b00;
                alu_code_s   = ALU_SUB;
                result_src_s = 2'b00;
                if (funct3 == 3'b000) begin
                    pc_write_s = zero;
                    next_s     = S_FETCH;
                end else if ((funct3 == 3'b001) && bne_ok_s) begin
                    pc_write_s = ~zero;
                    next_s     = S_FETCH;
                end else begin
                    pc_write_s = 1'b0;
                    next_s     = S_TRAP;
                end
            end
            S_JAL: begin
                // Jump to the target in ALUOut while computing OldPC+4 as the link.
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b00;
                pc_write_s   = 1'b1;
                next_s       = S_ALUWB;
            end
            S_JALR: begin
                // rs1+imm goes straight from the ALU into the PC.
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                pc_write_s   = 1'b1;
                next_s       = S_LINK;
            end
            S_LINK: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                next_s      = S_ALUWB;
            end
            S_LUI: begin
                // 0 + U-immediate.
                alu_src_a_s = 2'b11;
                alu_src_b_s = 2'b01;
                next_s      = S_ALUWB;
            end
            S_TRAP: begin
                next_s = S_TRAP;
            end
            default: begin
                next_s = S_TRAP;
            end
        endcase
    end

    // Immediate format straight from the opcode, independent of state.
    always_comb begin
        imm_code_s = IMM_I;
        case (opcode)
            OP_STORE:  imm_code_s = IMM_S;
            OP_BRANCH: imm_code_s = IMM_B;
            OP_JAL:    imm_code_s = IMM_J;
            OP_LUI:    imm_code_s = IMM_U;
            default:   imm_code_s = IMM_I;
        endcase
    end

    // Write-type enables are masked while reset is asserted.  An access cut
    // off by reset therefore cannot leave a write behind.
    assign pc_write    = pc_write_s  & rst_n;
    assign ir_write    = ir_write_s  & rst_n;
    assign reg_write   = reg_write_s & rst_n;
    assign mem_write   = mem_write_s & rst_n;
    assign adr_src     = adr_src_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign result_src  = result_src_s;
    assign alu_control = ALUCTRL_W'(alu_code_s);
    assign imm_src     = IMMSRC_W'(imm_code_s);
    assign illegal     = (state_r == S_TRAP);
    assign state_debug = state_r;

endmodule

// File: tb/tb_riscv_multiciclo_control.sv
// ---------------------------------------------------------------------------
// tb_riscv_multiciclo_control
//   Self-checking bench for riscv_multiciclo_control.  Two instances share the
//   stimulus: dut_a has JALR/BNE enabled and dut_b has both disabled.  Each
//   instruction is turned into its list of states from the instruction class.
//   A per-state control table gives the outputs expected in every cycle.
//   mem_ready is randomised, and the reference list only advances past a
//   memory state when the bench presents ready.
// ---------------------------------------------------------------------------
module tb_riscv_multiciclo_control;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1110011;

    // ALU code by funct3 (the R-type SUB case is handled separately).
    localparam logic [2:0] ALU_BY_F3 [8] = '{3'd0, 3'd6, 3'd2, 3'd0,
                                              3'd4, 3'd7, 3'd3, 3'd5};

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [2:0] alu;
        logic       illegal;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       sel_b = 1'b0;

    logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_illegal;
    logic [1:0] a_src_a, a_src_b, a_res;
    logic [2:0] a_alu, a_imm;
    logic [3:0] a_state;
    logic       b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write, b_illegal;
    logic [1:0] b_src_a, b_src_b, b_res;
    logic [2:0] b_alu, b_imm;
    logic [3:0] b_state;

    int checks = 0;
    int errors = 0;

    riscv_multiciclo_control dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .adr_src(a_adr_src), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .reg_write(a_reg_write), .alu_src_a(a_src_a),
        .alu_src_b(a_src_b), .result_src(a_res), .alu_control(a_alu),
        .imm_src(a_imm), .illegal(a_illegal), .state_debug(a_state)
    );

    riscv_multiciclo_control #(.SUPPORT_JALR(0), .SUPPORT_BNE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .reg_write(b_reg_write), .alu_src_a(b_src_a),
        .alu_src_b(b_src_b), .result_src(b_res), .alu_control(b_alu),
        .imm_src(b_imm), .illegal(b_illegal), .state_debug(b_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic get_obs(output ctrl_t o, output logic [3:0] st, output logic [2:0] imm);
        if (sel_b) begin
            o = '{b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write,
                  b_src_a, b_src_b, b_res, b_alu, b_illegal};
            st = b_state;
            imm = b_imm;
        end else begin
            o = '{a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write,
                  a_src_a, a_src_b, a_res, a_alu, a_illegal};
            st = a_state;
            imm = a_imm;
        end
    endtask

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            OP_STORE:  return 3'd1;
            OP_BRANCH: return 3'd2;
            OP_JAL:    return 3'd3;
            OP_LUI:    return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    // Control table: what each named step of the instruction must present.
    function automatic ctrl_t exp_ctrl(input int st, input logic [2:0] f3, input logic f7,
                                       input logic z, input logic rdy, input bit bne_ok);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.src_b = 2'b10; c.res = 2'b10; c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.src_a = 2'b01; c.src_b = 2'b01; end
            2:  begin c.src_a = 2'b10; c.src_b = 2'b01; end
            3:  begin c.adr_src = 1'b1; end
            4:  begin c.res = 2'b01; c.reg_write = 1'b1; end
            5:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            6:  begin c.src_a = 2'b10; c.alu = (f3 == 3'd0 && f7) ? 3'd1 : ALU_BY_F3[f3]; end
            7:  begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu = ALU_BY_F3[f3]; end
            8:  begin c.reg_write = 1'b1; end
            9:  begin
                    c.src_a = 2'b10; c.alu = 3'd1;
                    if (f3 == 3'd0) c.pc_write = z;
                    else if (f3 == 3'd1 && bne_ok) c.pc_write = !z;
                    else c.pc_write = 1'b0;
                end
            10: begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
            11: begin c.src_a = 2'b10; c.src_b = 2'b01; c.res = 2'b10; c.pc_write = 1'b1; end
            12: begin c.src_a = 2'b01; c.src_b = 2'b10; end
            13: begin c.src_a = 2'b11; c.src_b = 2'b01; end
            default: begin c.illegal = 1'b1; end
        endcase
        return c;
    endfunction

    // Reset both instances, check the reset state, release with mem_ready low
    // so FETCH is still current at the next negedge.
    task automatic do_reset();
        ctrl_t o;
        logic [3:0] st;
        logic [2:0] imm;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        get_obs(o, st, imm);
        check_eq("rst_ir_write_low", o.ir_write, 0);
        check_eq("rst_pc_write_low", o.pc_write, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        get_obs(o, st, imm);
        check_eq("rst_state", st, 0);
        check_eq("rst_illegal", o.illegal, 0);
        check_eq("rst_reg_write", o.reg_write, 0);
        check_eq("rst_mem_write", o.mem_write, 0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    // Run one instruction from FETCH.  mem_stall >= 0 fixes the number of
    // not-ready cycles in MEMREAD/MEMWRITE.  abort_st >= 0 asserts reset
    // in that state once a wait is in progress.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fetch_stall_pct, input int mem_stall,
                             input int abort_st, output int mw_cycles, output bit trapped);
        int seq[$];
        int idx, st_e, stall_run, mem_left, trap_cycles, guard;
        logic rdy;
        bit jalr_ok, bne_ok;
        ctrl_t o, e;
        logic [3:0] st;
        logic [2:0] imm;
        jalr_ok = !sel_b;
        bne_ok = !sel_b;
        case (op)
            OP_LOAD:   seq = '{0, 1, 2, 3, 4};
            OP_STORE:  seq = '{0, 1, 2, 5};
            OP_RTYPE:  seq = '{0, 1, 6, 8};
            OP_ITYPE:  seq = '{0, 1, 7, 8};
            OP_BRANCH: if (f3 == 3'd0 || (f3 == 3'd1 && bne_ok)) seq = '{0, 1, 9};
                       else seq = '{0, 1, 9, 14};
            OP_JAL:    seq = '{0, 1, 10, 8};
            OP_JALR:   if (jalr_ok) seq = '{0, 1, 11, 12, 8}; else seq = '{0, 1, 14};
            OP_LUI:    seq = '{0, 1, 13, 8};
            default:   seq = '{0, 1, 14};
        endcase
        trapped = (seq[seq.size() - 1] == 14);
        idx = 0; stall_run = 0; mem_left = mem_stall; trap_cycles = 0; guard = 0;
        mw_cycles = 0;
        while (idx < seq.size()) begin
            @(negedge clk);
            opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
            st_e = seq[idx];
            if (st_e == 0)
                rdy = (stall_run >= 4) || ($urandom_range(0, 99) >= fetch_stall_pct);
            else if ((st_e == 3 || st_e == 5) && mem_stall >= 0)
                rdy = (mem_left == 0);
            else if (st_e == 3 || st_e == 5)
                rdy = (stall_run >= 4) || ($urandom_range(0, 1) == 1);
            else
                rdy = ($urandom_range(0, 1) == 1);
            mem_ready = rdy;
            if (st_e == abort_st && stall_run >= 1) begin
                rst_n = 1'b0;
                mem_ready = 1'b1;
                #1;
                get_obs(o, st, imm);
                check_eq("abort_pc_write", o.pc_write, 0);
                check_eq("abort_ir_write", o.ir_write, 0);
                check_eq("abort_reg_write", o.reg_write, 0);
                check_eq("abort_mem_write", o.mem_write, 0);
                @(posedge clk);
                #1;
                get_obs(o, st, imm);
                check_eq("abort_state_fetch", st, 0);
                check_eq("abort_mem_write_after", o.mem_write, 0);
                @(negedge clk);
                mem_ready = 1'b0;
                rst_n = 1'b1;
                trapped = 1'b0;
                return;
            end
            #1;
            get_obs(o, st, imm);
            e = exp_ctrl(st_e, f3, f7, z, rdy, bne_ok);
            check_eq("state", st, st_e);
            check_eq("pc_write", o.pc_write, e.pc_write);
            check_eq("adr_src", o.adr_src, e.adr_src);
            check_eq("mem_write", o.mem_write, e.mem_write);
            check_eq("ir_write", o.ir_write, e.ir_write);
            check_eq("reg_write", o.reg_write, e.reg_write);
            check_eq("alu_src_a", o.src_a, e.src_a);
            check_eq("alu_src_b", o.src_b, e.src_b);
            check_eq("result_src", o.res, e.res);
            check_eq("alu_control", o.alu, e.alu);
            check_eq("illegal", o.illegal, e.illegal);
            check_eq("imm_src", imm, exp_imm(op));
            if (o.mem_write) mw_cycles++;
            if (st_e == 14) begin
                trap_cycles++;
                if (trap_cycles >= 3) idx = seq.size();
            end else if ((st_e == 0 || st_e == 3 || st_e == 5) && !rdy) begin
                stall_run++;
                if (st_e != 0 && mem_left > 0) mem_left--;
            end else begin
                idx++;
                stall_run = 0;
            end
            guard++;
            if (guard > 200) begin
                check_eq("instr_cycle_budget", guard, 200);
                idx = seq.size();
            end
        end
    endtask

    initial begin
        int mw;
        bit tr;
        logic [6:0] ops [9];
        logic [2:0] f3;
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                OP_JAL, OP_JALR, OP_LUI, OP_BAD};

        do_reset();

        // ADDI x1,x0,5 with memory always ready.
        run_instr(OP_ITYPE, 3'd0, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        // R-type add and sub.
        run_instr(OP_RTYPE, 3'd0, 1'b1, 1'b0, 0, 0, -1, mw, tr);
        run_instr(OP_RTYPE, 3'd0, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        // SW with three not-ready cycles in MEMWRITE.
        run_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 0, 3, -1, mw, tr);
        check_eq("sw_mem_write_cycles", mw, 4);
        run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 2, -1, mw, tr);
        // BEQ taken, BNE not taken, JAL, JALR, LUI.
        run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b1, 0, 0, -1, mw, tr);
        run_instr(OP_BRANCH, 3'd1, 1'b0, 1'b1, 0, 0, -1, mw, tr);
        run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        run_instr(OP_JALR, 3'd0, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        run_instr(OP_LUI, 3'd0, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        // Unsupported branch funct3 traps.
        run_instr(OP_BRANCH, 3'd4, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        check_eq("blt_traps", tr, 1);
        do_reset();

        // Reset during MEMREAD wait, FETCH stall and MEMWRITE wait.
        run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 3, 3, mw, tr);
        run_instr(OP_ITYPE, 3'd0, 1'b0, 1'b0, 100, 0, 0, mw, tr);
        run_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 0, 3, 5, mw, tr);
        run_instr(OP_ITYPE, 3'd4, 1'b0, 1'b0, 0, 0, -1, mw, tr);

        // Random instruction stream with random stalls.
        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            run_instr(ops[$urandom_range(0, 8)], f3, ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 1) == 1), 30, -1, -1, mw, tr);
            if (tr) do_reset();
        end

        // Reduced configuration: JALR and BNE are illegal.
        sel_b = 1'b1;
        do_reset();
        run_instr(OP_JALR, 3'd0, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        check_eq("b_jalr_traps", tr, 1);
        do_reset();
        run_instr(OP_BRANCH, 3'd1, 1'b0, 1'b0, 0, 0, -1, mw, tr);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(0, 7));
            run_instr(ops[$urandom_range(0, 8)], f3, ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 1) == 1), 30, -1, -1, mw, tr);
            if (tr) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
